write_edge: RTL
===============

# write_edge

Writer counterpart of the edge-list page reader: accepts a stream of edges (destination address, cost) for one adjacency list and packs them into linked pages in the format the page reader consumes. Each page is one header word {next_page_addr, page_size} followed by page_size edge words {cost, addr}. Pages are staged in a local buffer, announced to the control thread `cthread_write_edge` over a CoramChannel, then streamed out through a CoramOutStream for DMA to memory.

## Interface
Parameters:
- W_D, 32, width of one address/cost field; stream word width is 2*W_D.
- W_A, 10, CoramOutStream address length.
- W_COMM_A, 6, CoramChannel address length.
- PAGE_ENTRIES, 8, maximum edges per page; 1 ≤ PAGE_ENTRIES ≤ 2^W_BUF.
- W_BUF, 4, address width of the local page buffer.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- req_addr  in  W_D  byte address of the first page of the list.
- req_valid  in  1  start request.
- req_ready  out  1  high only in IDLE while the channel is not almost full.
- data_valid  in  1  edge beat valid.
- data_ready  out  1  high only in FILL.
- data_end  in  1  marks the last edge of the list; sampled with data_valid && data_ready.
- next_addr  in  W_D  edge destination address.
- next_cost  in  W_D  edge cost.

## Operation
- States: IDLE, FILL, ANN_ADDR, ANN_SIZE, HDR, DRAIN.
- IDLE: on req_valid && req_ready, latch page_addr=req_addr, count=0, go to FILL.
- FILL: each accepted beat writes {next_cost,next_addr} to buffer[count], count++. If the beat has data_end, set last=1, next_page_addr=0. Otherwise, if count reaches PAGE_ENTRIES, set last=0 and next_page_addr=page_addr+(PAGE_ENTRIES+1)*(2*W_D/8). In either case set page_size=count+1 and go to ANN_ADDR. A data_end on the PAGE_ENTRIES-th beat gives next_page_addr=0 and no further page.
- ANN_ADDR: when !comm_almost_full, enqueue page_addr to the channel and go to ANN_SIZE.
- ANN_SIZE: when !comm_almost_full, enqueue page_size+1 (word count including the header) and go to HDR.
- HDR: when !out_almost_full, enqueue {next_page_addr, page_size} and go to DRAIN.
- DRAIN: read buffer[0..page_size-1] in order and enqueue each word when !out_almost_full. After the last word:
  - if last, go to IDLE;
  - otherwise set page_addr=next_page_addr, count=0, and go to FILL.
- All arithmetic is W_D bits and wraps modulo 2^W_D. The block does not check for address overflow.
- Channel receive side (Q/DEQ) is tied off; DEQ=0.

## Timing
- Reset values: req_ready=0 and data_ready=0 during the reset cycle. Internally: state=IDLE, count=0, all enq strobes 0. req_ready is 1 in the first cycle after reset if the channel is not almost full.
- data_ready is combinational from state only. It never depends on data_valid.
- Up to one edge is accepted per cycle in FILL. There are no stalls while the buffer is not full.
- Buffer is synchronous-read with 1-cycle latency. DRAIN pipelines it so that one word is enqueued per cycle when out_almost_full stays low.
- ENQ is registered. There is never an ENQ in a cycle after ALM_FULL was observed high at the decision edge.
- Latency after the closing beat: channel address at +1, size at +2, header at +3, first edge at +4 (no backpressure).
- Stream words per page are exactly page_size+1. Channel messages for a page always precede any stream word of that page.
- RST mid-operation: return to IDLE next cycle. The partial page is discarded and no further ENQ is issued.

## Configuration
- WRITE_EDGE_STATS_EN defined: adds output ports edge_total [W_D] and page_total [W_D].
  - Both reset to 0.
  - edge_total increments per accepted edge beat.
  - page_total increments per header enqueued.
  - Both are cumulative across requests and wrap modulo 2^W_D.
- WRITE_EDGE_STATS_EN undefined: no such ports or counters. Behaviour is otherwise identical.

## Test plan
- PAGE_ENTRIES=4, W_D=32, req 0x1000, 3 edges, data_end on the 3rd -> channel 0x1000, 4. Stream {0,3}, then the 3 edges in order. req_ready returns.
- 4 edges, data_end on the 4th -> channel 0x1000, 5. Header {0,4}. No second page.
- 6 edges from 0x1000 -> page 1: channel 0x1000, 5, header {0x1028,4}. Page 2: channel 0x1028, 3, header {0,2}, then edges 5 and 6.
- out_almost_full held high 10 cycles mid-DRAIN -> no ENQ in that window. Word order and count unchanged; completes after release.
- comm_almost_full high at page close -> the block stalls in ANN_ADDR, data_ready=0, nothing on the stream until release.
- RST asserted during DRAIN, then a new req 0x2000 with 1 edge + end -> only channel 0x2000, 2 and stream {0,1}, edge. With WRITE_EDGE_STATS_EN, edge_total and page_total equal 0 after reset.

Source files
------------

// File: rtl/write_edge.sv
// write_edge: packs a stream of (addr, cost) edges for one adjacency list
// into linked pages. Each page is a header word {next_page_addr, page_size}
// followed by page_size edge words {cost, addr}. Pages are staged in a local
// buffer. Each page is announced on the control channel as (page address,
// word count), then streamed out.
//
// Optional feature macro: WRITE_EDGE_STATS_EN adds the cumulative counters
// edge_total and page_total as extra output ports.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for a start request
// S_FILL     | accepting edge beats into the page buffer
// S_ANN_ADDR | waiting to enqueue the page address on the channel
// S_ANN_SIZE | waiting to enqueue the page word count on the channel
// S_HDR      | waiting to enqueue the page header on the stream
// S_DRAIN    | streaming buffered edges, one word per free cycle

module write_edge #(
    parameter int W_D          = 32,
    parameter int W_A          = 10,
    parameter int W_COMM_A     = 6,
    parameter int PAGE_ENTRIES = 8,
    parameter int W_BUF        = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [W_D-1:0]     req_addr,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               data_valid,
    output logic               data_ready,
    input  logic               data_end,
    input  logic [W_D-1:0]     next_addr,
    input  logic [W_D-1:0]     next_cost,
    output logic [W_D-1:0]     comm_d_o,
    output logic               comm_enq_o,
    input  logic               comm_almost_full_i,
    output logic               comm_deq_o,
    output logic [2*W_D-1:0]   out_d_o,
    output logic               out_enq_o,
    input  logic               out_almost_full_i
`ifdef WRITE_EDGE_STATS_EN
    ,
    output logic [W_D-1:0]     edge_total,
    output logic [W_D-1:0]     page_total
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FILL     = 3'd1;
    localparam logic [2:0] S_ANN_ADDR = 3'd2;
    localparam logic [2:0] S_ANN_SIZE = 3'd3;
    localparam logic [2:0] S_HDR      = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;

    localparam int DEPTH = 1 << W_BUF;

    // Counters are one bit wider than the buffer index so that a full page
    // (PAGE_ENTRIES == DEPTH) is representable.
    localparam logic [W_BUF:0]   CNT_ONE    = (W_BUF + 1)'(1);
    localparam logic [W_BUF:0]   CNT_FULL   = (W_BUF + 1)'(PAGE_ENTRIES);
    localparam logic [W_D-1:0]   D_ONE      = W_D'(1);
    // Byte stride between consecutive pages: header plus a full set of edges.
    localparam logic [W_D-1:0]   PAGE_BYTES = W_D'((PAGE_ENTRIES + 1) * (2 * W_D / 8));

    // Elaboration-time sanity checks on the parameter set.
    if (PAGE_ENTRIES < 1 || PAGE_ENTRIES > DEPTH) begin : g_bad_entries
        $error("write_edge: PAGE_ENTRIES must be in 1..2**W_BUF");
    end
    if (PAGE_ENTRIES + 1 > (1 << W_A)) begin : g_bad_stream_len
        $error("write_edge: a page does not fit the stream transfer length");
    end
    if ((1 << W_COMM_A) < 2) begin : g_bad_comm_depth
        $error("write_edge: channel must hold both announce words");
    end
    if ((W_D % 8) != 0 || W_D <= W_BUF + 1) begin : g_bad_width
        $error("write_edge: W_D must be a byte multiple wider than the counters");
    end

    logic [2:0]         state_q, state_d;
    logic [W_BUF:0]     count_q, count_d;
    logic [W_BUF:0]     page_size_q, page_size_d;
    logic [W_BUF:0]     rd_idx_q, rd_idx_d;
    logic [W_D-1:0]     page_addr_q, page_addr_d;
    logic [W_D-1:0]     next_page_addr_q, next_page_addr_d;
    logic               last_q, last_d;

    logic               comm_enq_q, comm_enq_d;
    logic [W_D-1:0]     comm_d_q, comm_d_d;
    logic               out_enq_q, out_enq_d;
    logic [2*W_D-1:0]   out_d_q, out_d_d;

    logic [2*W_D-1:0]   buf_mem [DEPTH];
    logic [2*W_D-1:0]   rd_data_q;
    logic               rd_en;
    logic [W_BUF-1:0]   rd_addr;

    logic               beat;
    logic               hdr_fire;
    logic [W_BUF:0]     count_inc;
    logic [W_BUF:0]     rd_idx_inc;

    // Handshake outputs are held low while reset is asserted, whatever the
    // state register still holds during that cycle.
    assign req_ready  = (state_q == S_IDLE) && !comm_almost_full_i && !RST;
    assign data_ready = (state_q == S_FILL) && !RST;
    assign beat       = data_valid && data_ready;
    assign hdr_fire   = (state_q == S_HDR) && !out_almost_full_i;
    assign count_inc  = count_q + CNT_ONE;
    assign rd_idx_inc = rd_idx_q + CNT_ONE;

    assign comm_d_o   = comm_d_q;
    assign comm_enq_o = comm_enq_q;
    assign comm_deq_o = 1'b0;
    assign out_d_o    = out_d_q;
    assign out_enq_o  = out_enq_q;

    // Next-state, buffer read control and enqueue decisions.
    always_comb begin
        state_d          = state_q;
        count_d          = count_q;
        page_size_d      = page_size_q;
        rd_idx_d         = rd_idx_q;
        page_addr_d      = page_addr_q;
        next_page_addr_d = next_page_addr_q;
        last_d           = last_q;
        comm_enq_d       = 1'b0;
        comm_d_d         = comm_d_q;
        out_enq_d        = 1'b0;
        out_d_d          = out_d_q;
        rd_en            = 1'b0;
        rd_addr          = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    page_addr_d = req_addr;
                    count_d     = '0;
                    state_d     = S_FILL;
                end
            end

            S_FILL: begin
                if (beat) begin
                    count_d = count_inc;
                    // data_end wins over a full page: no empty trailing page.
                    if (data_end) begin
                        last_d           = 1'b1;
                        next_page_addr_d = '0;
                        page_size_d      = count_inc;
                        state_d          = S_ANN_ADDR;
                    end else if (count_inc == CNT_FULL) begin
                        last_d           = 1'b0;
                        next_page_addr_d = page_addr_q + PAGE_BYTES;
                        page_size_d      = count_inc;
                        state_d          = S_ANN_ADDR;
                    end
                end
            end

            S_ANN_ADDR: begin
                if (!comm_almost_full_i) begin
                    comm_enq_d = 1'b1;
                    comm_d_d   = page_addr_q;
                    state_d    = S_ANN_SIZE;
                end
            end

            S_ANN_SIZE: begin
                if (!comm_almost_full_i) begin
                    comm_enq_d = 1'b1;
                    comm_d_d   = W_D'(page_size_q) + D_ONE;
                    state_d    = S_HDR;
                end
            end

            S_HDR: begin
                if (!out_almost_full_i) begin
                    out_enq_d = 1'b1;
                    out_d_d   = {next_page_addr_q, W_D'(page_size_q)};
                    // Prefetch edge 0 so DRAIN can emit it on its first cycle.
                    rd_en     = 1'b1;
                    rd_addr   = '0;
                    rd_idx_d  = '0;
                    state_d   = S_DRAIN;
                end
            end

            S_DRAIN: begin
                // rd_data_q always holds edge rd_idx_q here; it is only
                // replaced once that edge has been enqueued.
                if (!out_almost_full_i) begin
                    out_enq_d = 1'b1;
                    out_d_d   = rd_data_q;
                    if (rd_idx_inc == page_size_q) begin
                        if (last_q) begin
                            state_d = S_IDLE;
                        end else begin
                            page_addr_d = next_page_addr_q;
                            count_d     = '0;
                            state_d     = S_FILL;
                        end
                    end else begin
                        rd_en    = 1'b1;
                        rd_addr  = rd_idx_inc[W_BUF-1:0];
                        rd_idx_d = rd_idx_inc;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers and registered enqueue strobes/data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q          <= S_IDLE;
            count_q          <= '0;
            page_size_q      <= '0;
            rd_idx_q         <= '0;
            page_addr_q      <= '0;
            next_page_addr_q <= '0;
            last_q           <= 1'b0;
            comm_enq_q       <= 1'b0;
            comm_d_q         <= '0;
            out_enq_q        <= 1'b0;
            out_d_q          <= '0;
        end else begin
            state_q          <= state_d;
            count_q          <= count_d;
            page_size_q      <= page_size_d;
            rd_idx_q         <= rd_idx_d;
            page_addr_q      <= page_addr_d;
            next_page_addr_q <= next_page_addr_d;
            last_q           <= last_d;
            comm_enq_q       <= comm_enq_d;
            comm_d_q         <= comm_d_d;
            out_enq_q        <= out_enq_d;
            out_d_q          <= out_d_d;
        end
    end

    // Page buffer write port: one edge per accepted beat.
    always_ff @(posedge CLK) begin
        if (beat) begin
            buf_mem[count_q[W_BUF-1:0]] <= {next_cost, next_addr};
        end
    end

    // Page buffer read port: synchronous, holds its word until the next read.
    always_ff @(posedge CLK) begin
        if (rd_en) begin
            rd_data_q <= buf_mem[rd_addr];
        end
    end

`ifdef WRITE_EDGE_STATS_EN
    logic [W_D-1:0] edge_total_q;
    logic [W_D-1:0] page_total_q;

    assign edge_total = edge_total_q;
    assign page_total = page_total_q;

    // Cumulative edge and page counters, wrapping at 2**W_D.
    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_total_q <= '0;
            page_total_q <= '0;
        end else begin
            if (beat) begin
                edge_total_q <= edge_total_q + D_ONE;
            end
            if (hdr_fire) begin
                page_total_q <= page_total_q + D_ONE;
            end
        end
    end
`else
    // Without the counters, the header-enqueue qualifier has no consumer.
    logic unused_hdr_fire;
    assign unused_hdr_fire = hdr_fire;
`endif

endmodule
